// File: rtl/writeback_arbiter.sv
// Round-robin write-back arbiter feeding the single regfile write port through a registered stage.
// Define WB_ARB_FIXED_PRIO_EN for fixed priority (pipe 0 highest) instead of round-robin.
module writeback_arbiter #(
    parameter type t_entry     = logic [31:0],
    parameter int  p_num_regs  = 32,
    parameter int  p_num_pipes = 2,
    localparam int p_addr_bits = $clog2(p_num_regs),
    localparam int p_ptr_bits  = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [p_num_pipes-1:0]                  pipe_val,
    output logic [p_num_pipes-1:0]                  pipe_rdy,
    input  logic [p_num_pipes-1:0][p_addr_bits-1:0] pipe_waddr,
    input  t_entry                                  pipe_wdata [p_num_pipes],
    output logic [p_addr_bits-1:0]                  waddr,
    output t_entry                                  wdata,
    output logic                                    wen
);

    logic [p_num_pipes-1:0] grant;
    logic [p_num_pipes-1:0] fire;
    logic                   fire_any;
    logic [p_ptr_bits-1:0]  sel;

    logic [p_addr_bits-1:0] waddr_p1;
    t_entry                 wdata_p1;
    logic                   wen_p1;

`ifdef WB_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = '0;
        for (int i = p_num_pipes - 1; i >= 0; i--) begin
            if (pipe_val[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end
`else
    logic [p_ptr_bits-1:0] ptr;

    // Two passes: requesters at or above ptr first, then the wrapped-around ones below it.
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < p_num_pipes; i++) begin
            if (!found && pipe_val[i] && (i >= int'(ptr))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < p_num_pipes; i++) begin
            if (!found && pipe_val[i] && (i < int'(ptr))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

    assign pipe_rdy = grant & {p_num_pipes{~rst}};
    assign fire     = pipe_val & pipe_rdy;
    assign fire_any = |fire;

    always_comb begin
        sel = '0;
        for (int i = 0; i < p_num_pipes; i++) begin
            if (fire[i]) sel = p_ptr_bits'(i);
        end
    end

`ifndef WB_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (fire_any) begin
            ptr <= (sel == p_ptr_bits'(p_num_pipes - 1)) ? '0 : sel + 1'b1;
        end
    end
`endif

    // Stage p1: registered write port; writes to x0 complete the handshake but never assert wen.
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_p1   <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= t_entry'('0);
        end else begin
            wen_p1 <= fire_any && (pipe_waddr[sel] != '0);
            if (fire_any) begin
                waddr_p1 <= pipe_waddr[sel];
                wdata_p1 <= pipe_wdata[sel];
            end
        end
    end

    assign waddr = waddr_p1;
    assign wdata = wdata_p1;
    assign wen   = wen_p1;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: 2-pipe and 3-pipe instances, expected writes queued per cycle.
module tb_writeback_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]      val2, rdy2;
    logic [1:0][4:0] aw2;
    logic [31:0]     dw2 [2];
    logic [4:0]      waddr2;
    logic [31:0]     wdata2;
    logic            wen2;

    logic [2:0]      val3, rdy3;
    logic [2:0][4:0] aw3;
    logic [31:0]     dw3 [3];
    logic [4:0]      waddr3;
    logic [31:0]     wdata3;
    logic            wen3;

    writeback_arbiter #(.t_entry(logic [31:0]), .p_num_regs(32), .p_num_pipes(2)) dut2 (
        .clk(clk), .rst(rst), .pipe_val(val2), .pipe_rdy(rdy2), .pipe_waddr(aw2),
        .pipe_wdata(dw2), .waddr(waddr2), .wdata(wdata2), .wen(wen2)
    );

    writeback_arbiter #(.t_entry(logic [31:0]), .p_num_regs(32), .p_num_pipes(3)) dut3 (
        .clk(clk), .rst(rst), .pipe_val(val3), .pipe_rdy(rdy3), .pipe_waddr(aw3),
        .pipe_wdata(dw3), .waddr(waddr3), .wdata(wdata3), .wen(wen3)
    );

    typedef struct packed {
        logic        wen;
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t q[$];
    exp_t last2, last3;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive valids, check grant, queue the write expected next cycle, then compare it.
    task automatic cycle(input string tag, input int which, input logic [2:0] v,
                         input logic [2:0] er, input logic r);
        exp_t       e, obs;
        logic [2:0] obs_rdy;
        rst = r;
        if (which == 2) begin val2 = v[1:0]; val3 = '0; end
        else            begin val3 = v;      val2 = '0; end
        #1;
        obs_rdy = (which == 2) ? {1'b0, rdy2} : rdy3;
        chk({tag, ".pipe_rdy"}, 64'(obs_rdy), 64'(er));
        e = (which == 2) ? last2 : last3;
        e.wen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (er[i]) begin
                if (which == 2) begin e.a = aw2[i[0]]; e.d = dw2[i[0]]; end
                else            begin e.a = aw3[i];    e.d = dw3[i];    end
                e.wen = (e.a != 5'd0);
            end
        end
        if (r) begin
            e = '0; last2 = '0; last3 = '0;
        end else if (which == 2) last2 = e;
        else                     last3 = e;
        q.push_back(e);
        @(posedge clk);
        #1;
        e   = q.pop_front();
        obs = (which == 2) ? {wen2, waddr2, wdata2} : {wen3, waddr3, wdata3};
        chk({tag, ".wen"},   64'(obs.wen), 64'(e.wen));
        chk({tag, ".waddr"}, 64'(obs.a),   64'(e.a));
        chk({tag, ".wdata"}, 64'(obs.d),   64'(e.d));
    endtask

    initial begin
        rst = 1'b1; val2 = '0; val3 = '0;
        aw2 = '0; aw3 = '0;
        dw2[0] = '0; dw2[1] = '0; dw3[0] = '0; dw3[1] = '0; dw3[2] = '0;
        last2 = '0; last3 = '0;

        cycle("reset", 2, 3'b000, 3'b000, 1'b1);
        cycle("reset", 2, 3'b011, 3'b000, 1'b1);

        aw2[0] = 5'd5; dw2[0] = 32'habcd;
        cycle("single", 2, 3'b001, 3'b001, 1'b0);
        cycle("single_idle", 2, 3'b000, 3'b000, 1'b0);

        aw2[1] = 5'd0; dw2[1] = 32'hbaad;
        cycle("x0", 2, 3'b010, 3'b010, 1'b0);
        cycle("x0_idle", 2, 3'b000, 3'b000, 1'b0);

        aw2[0] = 5'd6; dw2[0] = 32'h1234;
        aw2[1] = 5'd7; dw2[1] = 32'h5678;
`ifdef WB_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) cycle("fixed", 2, 3'b011, 3'b001, 1'b0);
        cycle("fixed_p1", 2, 3'b010, 3'b010, 1'b0);
        cycle("fixed_p0", 2, 3'b001, 3'b001, 1'b0);
`else
        for (int k = 0; k < 2; k++) begin
            cycle("rr_g0", 2, 3'b011, 3'b001, 1'b0);
            cycle("rr_g1", 2, 3'b011, 3'b010, 1'b0);
        end
        cycle("rr_solo1", 2, 3'b010, 3'b010, 1'b0);
`endif

        // Pipe 1 fires, then reset lands while its write is on the port.
        cycle("rst_fire1", 2, 3'b010, 3'b010, 1'b0);
        cycle("rst_mid", 2, 3'b011, 3'b000, 1'b1);
        cycle("rst_after", 2, 3'b011, 3'b001, 1'b0);
        cycle("rst_after2", 2, 3'b010, 3'b010, 1'b0);

        for (int k = 0; k < 3; k++) begin
            aw2[0] = 5'(k + 9); dw2[0] = 32'hc000 + 32'(k);
            cycle("solo_stream", 2, 3'b001, 3'b001, 1'b0);
        end

        aw3[0] = 5'd1; dw3[0] = 32'haaaa;
        aw3[1] = 5'd2; dw3[1] = 32'hbbbb;
        aw3[2] = 5'd3; dw3[2] = 32'hcccc;
        for (int k = 0; k < 2; k++) begin
`ifdef WB_ARB_FIXED_PRIO_EN
            for (int j = 0; j < 3; j++) cycle("wrap_fixed", 3, 3'b111, 3'b001, 1'b0);
`else
            cycle("wrap_g0", 3, 3'b111, 3'b001, 1'b0);
            cycle("wrap_g1", 3, 3'b111, 3'b010, 1'b0);
            cycle("wrap_g2", 3, 3'b111, 3'b100, 1'b0);
`endif
        end
        cycle("wrap_idle", 3, 3'b000, 3'b000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
Producer side of the register file write port. Collects completed results from several execute pipes over val/rdy streams and grants one per cycle, round-robin. Drives the regfile's single write port (waddr/wdata/wen) from a registered output stage. Sits between the execute pipes and the regfile in decode_issue; its outputs connect directly to the regfile write port.

Parameters:
t_entry, logic [31:0], data type of a register entry (type parameter).
p_num_regs, 32, number of architectural registers; p_addr_bits = $clog2(p_num_regs).
p_num_pipes, 2, number of completion streams; legal range 1..8.

Ports:
clk  input  1  clock.
rst  input  1  reset.
pipe_val  input  [p_num_pipes]  completion valid, per pipe.
pipe_rdy  output  [p_num_pipes]  completion accepted, per pipe.
pipe_waddr  input  [p_num_pipes] x p_addr_bits  destination register, per pipe.
pipe_wdata  input  [p_num_pipes] x t_entry  result data, per pipe.
waddr  output  p_addr_bits  regfile write address.
wdata  output  t_entry  regfile write data.
wen  output  1  regfile write enable.

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset values: wen=0, waddr=0, wdata=0, priority pointer ptr=0. pipe_rdy is all-zero while rst=1, so no request is accepted in a reset cycle.
- Grant:
  - One-hot over requesting pipes.
  - Search starts at ptr, ascending, wrapping modulo p_num_pipes.
  - No requesters gives grant=0.
  - pipe_rdy = grant & ~{rst}.
  - pipe_rdy[i] depends combinationally on pipe_val but never on pipe_waddr or pipe_wdata.
- Fire: pipe i fires when pipe_val[i] & pipe_rdy[i]. At most one pipe fires per cycle.
- Pointer update:
  - When pipe i fires, ptr becomes (i+1) mod p_num_pipes on the next edge.
  - With no fire, ptr holds.
  - The pointer wraps from p_num_pipes-1 to 0.
- Output stage, 1-cycle latency:
  - On the edge ending a fire cycle: waddr/wdata take the fired pipe's values; wen = (fired waddr != 0).
  - A write to x0 is consumed (handshake completes) but wen stays 0.
  - On a cycle with no fire: wen=0 next cycle; waddr and wdata hold their previous values.
- Back-pressure: none from the regfile. The output stage never stalls, so a continuously valid single pipe fires every cycle.
- Fairness: with all N pipes continuously valid, each pipe is granted exactly once in any N consecutive cycles.
- Same-address writes from different pipes in consecutive cycles are written in grant order; the later grant wins in the regfile.
- A pipe must hold pipe_val, pipe_waddr and pipe_wdata stable until it fires. Dropping val before fire is a protocol violation.
- Reset mid-operation:
  - Any in-flight registered write is discarded (wen=0 next cycle).
  - ptr returns to 0.
  - Pending pipe requests remain valid and are arbitrated afresh after reset deasserts.

Optional Feature:
WB_ARB_FIXED_PRIO_EN
- Defined: the round-robin pointer is removed and arbitration is fixed-priority, with pipe 0 highest and pipe N-1 lowest. A continuously valid pipe 0 starves all others, and that starvation is the intended behaviour.
- Undefined: round-robin as specified under Behaviour.
- All other behaviour (latency, x0 suppression, reset) is identical with and without the macro.

Test Plan:
- Single write: pipe 0 presents val=1, waddr=5, wdata=0xabcd for one cycle. Expected: pipe_rdy[0]=1 that cycle; next cycle wen=1, waddr=5, wdata=0xabcd; the cycle after, wen=0.
- x0 suppression: pipe 1 presents waddr=0, wdata=0xbaad. Expected: pipe_rdy[1]=1; next cycle wen=0.
- Round-robin, p_num_pipes=2: both pipes continuously valid, pipe0 (waddr=6, wdata=0x1234) and pipe1 (waddr=7, wdata=0x5678). Expected: grants alternate 0,1,0,1 starting from ptr=0; wen=1 every cycle with waddr alternating 6,7,6,7.
- Wrap, p_num_pipes=3: all three pipes valid for 6 cycles. Expected: grant order 0,1,2,0,1,2.
- Reset mid-stream: pipe 1 fires at cycle k, then rst=1 at cycle k+1. Expected: wen=0 at k+2 and pipe_rdy=0 during rst. After rst drops, with both pipes valid, pipe 0 is granted first.
- Fixed-priority build (WB_ARB_FIXED_PRIO_EN defined): both pipes valid for 4 cycles. Expected: pipe 0 granted all 4 cycles; pipe 1 is granted on the first cycle after pipe 0 drops val.
